// File: rtl/vmul_sew_pipe_if.sv
// Operand/result handshake bundle for the SEW-configurable packed multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface vmul_sew_pipe_if #(
    parameter int DATA_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            sew;
    logic [1:0]            op;
    logic [DATA_W-1:0]     data_in_A;
    logic [DATA_W-1:0]     data_in_B;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     result;
    logic [2*DATA_W-1:0]   product;
    logic                  illegal;

    modport master (
        output in_valid, sew, op, data_in_A, data_in_B, out_ready,
        input  in_ready, out_valid, result, product, illegal
    );

    modport slave (
        input  in_valid, sew, op, data_in_A, data_in_B, out_ready,
        output in_ready, out_valid, result, product, illegal
    );
endinterface

// File: rtl/vmul_sew_pipe.sv
// Lane-packed SIMD multiplier (SEW 8/16/32) with vmul/vmulh/vmulhu/vmulhsu modes,
// valid/ready on both sides and output hold while the consumer stalls.
module vmul_sew_pipe #(
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    vmul_sew_pipe_if.slave   bus
);

    localparam int L8  = DATA_W / 8;
    localparam int L16 = DATA_W / 16;
    localparam int L32 = DATA_W / 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [1:0]            sew_q, sew_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic [2*DATA_W-1:0]   product_q, product_d;
    logic                  illegal_q, illegal_d;
    logic                  in_ready_s;
    logic [2:0]            last_cnt_s;

    logic                  a_sgn_s, b_sgn_s, mul_lo_s;
    logic [7:0]            a8_s, b8_s;
    logic [15:0]           a16_s, b16_s, ae16_s, be16_s, p16_s;
    logic [31:0]           a32_s, b32_s, ae32_s, be32_s, p32_s;
    logic [63:0]           ae64_s, be64_s, p64_s;
    logic [2*DATA_W-1:0]   prod8_s, prod16_s, prod32_s;
    logic [DATA_W-1:0]     res8_s, res16_s, res32_s;

    // Operand signedness and half selection derived from the latched op
    always_comb begin
        a_sgn_s  = (op_q != 2'b10);
        b_sgn_s  = (op_q == 2'b00) || (op_q == 2'b01);
        mul_lo_s = (op_q == 2'b00);
    end

    // Per-lane full products: operands are extended to 2*SEW bits so the
    // truncated product equals the exact signed/unsigned lane product
    always_comb begin
        a8_s     = 8'h00;
        b8_s     = 8'h00;
        a16_s    = 16'h0000;
        b16_s    = 16'h0000;
        ae16_s   = 16'h0000;
        be16_s   = 16'h0000;
        p16_s    = 16'h0000;
        a32_s    = 32'h0000_0000;
        b32_s    = 32'h0000_0000;
        ae32_s   = 32'h0000_0000;
        be32_s   = 32'h0000_0000;
        p32_s    = 32'h0000_0000;
        ae64_s   = 64'h0;
        be64_s   = 64'h0;
        p64_s    = 64'h0;
        prod8_s  = '0;
        prod16_s = '0;
        prod32_s = '0;
        res8_s   = '0;
        res16_s  = '0;
        res32_s  = '0;
        for (int i = 0; i < L8; i++) begin
            a8_s   = a_q[8*i +: 8];
            b8_s   = b_q[8*i +: 8];
            ae16_s = {{8{a_sgn_s & a8_s[7]}}, a8_s};
            be16_s = {{8{b_sgn_s & b8_s[7]}}, b8_s};
            p16_s  = ae16_s * be16_s;
            prod8_s[16*i +: 16] = p16_s;
            res8_s[8*i +: 8]    = mul_lo_s ? p16_s[7:0] : p16_s[15:8];
        end
        for (int i = 0; i < L16; i++) begin
            a16_s  = a_q[16*i +: 16];
            b16_s  = b_q[16*i +: 16];
            ae32_s = {{16{a_sgn_s & a16_s[15]}}, a16_s};
            be32_s = {{16{b_sgn_s & b16_s[15]}}, b16_s};
            p32_s  = ae32_s * be32_s;
            prod16_s[32*i +: 32] = p32_s;
            res16_s[16*i +: 16]  = mul_lo_s ? p32_s[15:0] : p32_s[31:16];
        end
        for (int i = 0; i < L32; i++) begin
            a32_s  = a_q[32*i +: 32];
            b32_s  = b_q[32*i +: 32];
            ae64_s = {{32{a_sgn_s & a32_s[31]}}, a32_s};
            be64_s = {{32{b_sgn_s & b32_s[31]}}, b32_s};
            p64_s  = ae64_s * be64_s;
            prod32_s[64*i +: 64] = p64_s;
            res32_s[32*i +: 32]  = mul_lo_s ? p64_s[31:0] : p64_s[63:32];
        end
    end

    // Final counter value: C slice cycles plus one output-register cycle,
    // which makes out_valid rise exactly C+1 edges after acceptance
    always_comb begin
        case (sew_q)
            2'b00:   last_cnt_s = 3'd1;
            2'b01:   last_cnt_s = 3'd2;
            2'b10:   last_cnt_s = 3'd4;
            default: last_cnt_s = 3'd1;
        endcase
    end

    // Handshake FSM next-state, operand capture and output register loading
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sew_d       = sew_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        product_d   = product_q;
        illegal_d   = illegal_q;
        in_ready_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    sew_d   = bus.sew;
                    op_d    = bus.op;
                    a_d     = bus.data_in_A;
                    b_d     = bus.data_in_B;
                    cnt_d   = 3'd0;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_q == last_cnt_s) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    case (sew_q)
                        2'b00: begin
                            result_d  = res8_s;
                            product_d = prod8_s;
                            illegal_d = 1'b0;
                        end
                        2'b01: begin
                            result_d  = res16_s;
                            product_d = prod16_s;
                            illegal_d = 1'b0;
                        end
                        2'b10: begin
                            result_d  = res32_s;
                            product_d = prod32_s;
                            illegal_d = 1'b0;
                        end
                        default: begin
                            result_d  = '0;
                            product_d = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                in_ready_s = bus.out_ready;
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.in_valid) begin
                        sew_d   = bus.sew;
                        op_d    = bus.op;
                        a_d     = bus.data_in_A;
                        b_d     = bus.data_in_B;
                        cnt_d   = 3'd0;
                        state_d = S_CALC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            sew_q       <= 2'b00;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            product_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sew_q       <= sew_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            product_q   <= product_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.product   = product_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_vmul_sew_pipe.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_vmul_sew_pipe;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    bit   chk_en;

    vmul_sew_pipe_if #(.DATA_W(32)) bus ();

    vmul_sew_pipe #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: one output slot plus one pending transaction
    logic        m_valid;
    logic [31:0] m_res;
    logic [63:0] m_prod;
    logic        m_ill;
    logic        m_pend;
    int          m_left;
    logic [31:0] p_res;
    logic [63:0] p_prod;
    logic        p_ill;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int calc_cycles(input logic [1:0] s);
        if (s == 2'b01) return 2;
        if (s == 2'b10) return 4;
        return 1;
    endfunction

    function automatic void model_calc(input logic [1:0] s, input logic [1:0] o,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output logic [63:0] p, output logic [31:0] r,
                                       output logic ill);
        int          w;
        longint      sa, sb, pr;
        logic [63:0] ua, ub, lane, mw;
        p   = 64'h0;
        r   = 32'h0;
        ill = (s == 2'b11);
        if (!ill) begin
            w  = 8 << s;
            mw = (64'd1 << w) - 64'd1;
            for (int l = 0; l < 32 / w; l++) begin
                ua = {32'h0, a >> (w * l)} & mw;
                ub = {32'h0, b >> (w * l)} & mw;
                sa = $signed(ua);
                sb = $signed(ub);
                if (o != 2'b10 && ua[w-1]) sa = sa - (64'sd1 <<< w);
                if ((o == 2'b00 || o == 2'b01) && ub[w-1]) sb = sb - (64'sd1 <<< w);
                pr   = sa * sb;
                lane = pr;
                if (w < 32) lane = lane & ((64'd1 << (2 * w)) - 64'd1);
                p = p | (lane << (2 * w * l));
                if (o == 2'b00) r = r | 32'((lane & mw) << (w * l));
                else            r = r | 32'(((lane >> w) & mw) << (w * l));
            end
        end
    endfunction

    // Model update on each active edge using the inputs held since the falling edge
    always @(posedge clk) begin
        logic        v, pd, il, acc;
        logic [31:0] rr;
        logic [63:0] pp;
        int          lf;
        logic [63:0] np;
        logic [31:0] nr;
        logic        ni;
        v = m_valid; pd = m_pend; lf = m_left; rr = m_res; pp = m_prod; il = m_ill;
        np = p_prod; nr = p_res; ni = p_ill;
        if (reset) begin
            v = 1'b0; pd = 1'b0; lf = 0; rr = 32'h0; pp = 64'h0; il = 1'b0;
        end else begin
            acc = bus.in_valid && !pd && (!v || bus.out_ready);
            if (v && bus.out_ready) v = 1'b0;
            if (pd) begin
                lf = lf - 1;
                if (lf == 0) begin
                    pd = 1'b0; v = 1'b1; rr = p_res; pp = p_prod; il = p_ill;
                end
            end
            if (acc) begin
                model_calc(bus.sew, bus.op, bus.data_in_A, bus.data_in_B, np, nr, ni);
                pd = 1'b1;
                lf = calc_cycles(bus.sew) + 1;
            end
        end
        m_valid <= v; m_pend <= pd; m_left <= lf; m_res <= rr; m_prod <= pp; m_ill <= il;
        p_prod <= np; p_res <= nr; p_ill <= ni;
    end

    // Cycle-by-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("m_out_valid", {63'h0, bus.out_valid}, {63'h0, m_valid});
            chk("m_in_ready", {63'h0, bus.in_ready},
                {63'h0, (!m_pend && (!m_valid || bus.out_ready))});
            chk("m_result", {32'h0, bus.result}, {32'h0, m_res});
            chk("m_product", bus.product, m_prod);
            chk("m_illegal", {63'h0, bus.illegal}, {63'h0, m_ill});
        end
    end

    task automatic run(input string nm, input logic [1:0] s, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy,
                       input logic [31:0] er, input logic [63:0] ep, input logic ei,
                       input int elat);
        int lat;
        @(negedge clk);
        bus.sew = s; bus.op = o; bus.data_in_A = a; bus.data_in_B = b;
        bus.in_valid = 1'b1; bus.out_ready = ordy;
        #1;
        chk({nm, "_acc_ready"}, {63'h0, bus.in_ready}, 64'h1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data_in_A = $urandom;
        bus.data_in_B = $urandom;
        bus.op = 2'($urandom_range(0, 3));
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, 64'(lat), 64'(elat));
        chk({nm, "_result"}, {32'h0, bus.result}, {32'h0, er});
        chk({nm, "_product"}, bus.product, ep);
        chk({nm, "_illegal"}, {63'h0, bus.illegal}, {63'h0, ei});
    endtask

    initial begin
        n_checks = 0; n_fail = 0; chk_en = 1'b0;
        m_valid = 1'b0; m_pend = 1'b0; m_left = 0; m_res = 32'h0; m_prod = 64'h0; m_ill = 1'b0;
        p_res = 32'h0; p_prod = 64'h0; p_ill = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.sew = 2'b00; bus.op = 2'b00;
        bus.data_in_A = 32'h0; bus.data_in_B = 32'h0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("rst_result", {32'h0, bus.result}, 64'h0);
        chk("rst_product", bus.product, 64'h0);
        chk("rst_illegal", {63'h0, bus.illegal}, 64'h0);
        chk_en = 1'b1;

        run("s16_mul",    2'b01, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
            32'h00010001, 64'h0000000100000001, 1'b0, 3);
        run("s16_mulhu",  2'b01, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
            32'hFFFEFFFE, 64'hFFFE0001FFFE0001, 1'b0, 3);
        run("s8_mulh",    2'b00, 2'b01, 32'h80808080, 32'h80808080, 1'b1,
            32'h40404040, 64'h4000400040004000, 1'b0, 2);
        run("s32_mulhsu", 2'b10, 2'b11, 32'hFFFFFFFF, 32'h00000002, 1'b1,
            32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1'b0, 5);
        run("s32_mulhu",  2'b10, 2'b10, 32'hFFFFFFFF, 32'h00000002, 1'b1,
            32'h00000001, 64'h00000001FFFFFFFE, 1'b0, 5);
        run("s32_mul",    2'b10, 2'b00, 32'hFFFFFFFF, 32'h00000002, 1'b1,
            32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, 5);
        run("s8_mulhsu",  2'b00, 2'b11, 32'h80FF0102, 32'hFF02FF03, 1'b1,
            32'h80FF0000, 64'h8080FFFE00FF0006, 1'b0, 2);

        // Backpressure: result held and no acceptance while out_ready is low
        run("bp_first",   2'b00, 2'b00, 32'h05040302, 32'h02020202, 1'b0,
            32'h0A080604, 64'h000A000800060004, 1'b0, 2);
        bus.in_valid = 1'b1; bus.sew = 2'b01; bus.op = 2'b01;
        bus.data_in_A = 32'hFFFE0003; bus.data_in_B = 32'h00050007;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("bp_in_ready", {63'h0, bus.in_ready}, 64'h0);
            chk("bp_out_valid", {63'h0, bus.out_valid}, 64'h1);
            chk("bp_result_hold", {32'h0, bus.result}, 64'h0A080604);
        end
        run("b2b_second", 2'b01, 2'b01, 32'hFFFE0003, 32'h00050007, 1'b1,
            32'hFFFF0000, 64'hFFFFFFF600000015, 1'b0, 3);

        // Reset in the middle of a SEW32 calculation
        @(negedge clk);
        bus.sew = 2'b10; bus.op = 2'b00; bus.data_in_A = 32'h7; bus.data_in_B = 32'h9;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("mid_rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("mid_rst_result", {32'h0, bus.result}, 64'h0);
        chk("mid_rst_product", bus.product, 64'h0);

        run("sew_rsvd",   2'b11, 2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1,
            32'h00000000, 64'h0, 1'b1, 2);
        run("after_ill",  2'b01, 2'b00, 32'h00030002, 32'h00050004, 1'b1,
            32'h000F0008, 64'h0000000F00000008, 1'b0, 3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
